ifu_fetch: RTL and testbench

Instruction fetch unit: the initiator side of the instruction-memory read interface. Holds the PC, issues one word-aligned read request per instruction over a valid/ready handshake, accepts the memory response at arbitrary latency, and presents `{pc, inst}` to decode over a second valid/ready handshake. It sits between the instruction memory and the decode stage, and handles PC redirects from execute, including in-flight responses that must be discarded.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/ifu_out_buf.sv | 71 +++++++
 rtl/ifu_fetch.sv | 188 ++++++++++++++++++
 tb/tb_ifu_fetch.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//
// Shared definitions for the CPU front end.
//   ADDR_W      : PC and instruction-address width
//   INST_W      : instruction word width
//   RESET_PC    : PC value loaded when the core leaves reset
//   ifu_state_e : states of the instruction fetch FSM
//                 REQ  - presenting a read request to instruction memory
//                 WAIT - request accepted, waiting for the response word
//                 OUT  - holding a fetched instruction for decode
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int unsigned ADDR_W   = 64;
    localparam int unsigned INST_W   = 32;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        OUT  = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ifu_out_buf.sv
// ---------------------------------------------------------------------------
// ifu_out_buf
//
// Holding register between the fetch FSM and decode. It captures the pc,
// instruction word and fault flag of one fetched instruction and presents
// them on a valid/ready handshake until decode takes them or the entry is
// killed by a redirect.
//
// Ports
//   clk, rst : clock and synchronous active-high reset
//   i_load   : capture i_pc / i_inst / i_fault and raise o_valid
//   i_kill   : drop the held entry without handing it to decode
//   i_pc     : pc of the instruction being captured
//   i_inst   : instruction word being captured
//   i_fault  : fetch fault flag being captured
//   i_ready  : decode accepts the held entry
//   o_valid  : an entry is held
//   o_pc     : held pc
//   o_inst   : held instruction word
//   o_fault  : held fault flag
// ---------------------------------------------------------------------------
module ifu_out_buf
    import cpu_pkg::*;
#(
    parameter int unsigned BUF_ADDR_W = cpu_pkg::ADDR_W,
    parameter int unsigned BUF_INST_W = cpu_pkg::INST_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_kill,
    input  logic [BUF_ADDR_W-1:0] i_pc,
    input  logic [BUF_INST_W-1:0] i_inst,
    input  logic                  i_fault,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [BUF_ADDR_W-1:0] o_pc,
    output logic [BUF_INST_W-1:0] o_inst,
    output logic                  o_fault
);

    logic                  r_valid;
    logic [BUF_ADDR_W-1:0] r_pc;
    logic [BUF_INST_W-1:0] r_inst;
    logic                  r_fault;

    // The fetch FSM only loads while the buffer is empty, so a load never
    // collides with a consume. Data registers keep their value after the
    // entry leaves; only the valid bit matters downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_inst  <= '0;
            r_fault <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_inst  <= i_inst;
            r_fault <= i_fault;
        end else if (i_kill || (r_valid && i_ready)) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_inst  = r_inst;
    assign o_fault = r_fault;

endmodule

// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch
//
// Instruction fetch unit. Holds the PC, issues one word-aligned read per
// instruction to instruction memory (valid/ready), accepts the response at
// any latency and hands {pc, inst} to decode (valid/ready). Redirects from
// execute replace the PC at any time; a response belonging to a request
// issued before the redirect is discarded when it arrives.
//
// Optional feature macro: IFU_MISALIGN_CHECK_EN
//   defined   - a PC with pc[1:0] != 0 issues no memory request; an
//               instruction of 0 with out_fault=1 is presented instead.
//   undefined - pc[1:0] is ignored for addressing and out_fault stays 0.
//
// Ports
//   clk, rst         : clock and synchronous active-high reset
//   redirect_valid   : one-cycle pulse replacing the PC
//   redirect_pc      : new PC, taken unmodified
//   imem_req_valid   : read request pending
//   imem_req_ready   : memory accepts the request
//   imem_req_addr    : word-aligned read address
//   imem_resp_valid  : response word present (always accepted in WAIT)
//   imem_resp_inst   : response word
//   out_valid        : fetched instruction available to decode
//   out_ready        : decode accepts the instruction
//   out_pc           : pc of the presented instruction
//   out_inst         : presented instruction
//   out_fault        : misaligned-fetch fault flag
// ---------------------------------------------------------------------------
module ifu_fetch
#(
    parameter int unsigned          ADDR_W   = cpu_pkg::ADDR_W,
    parameter int unsigned          INST_W   = cpu_pkg::INST_W,
    parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(cpu_pkg::RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic              out_fault
);

    import cpu_pkg::*;

    ifu_state_e        r_state;
    ifu_state_e        w_stateNext;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pcNext;
    logic              r_drop;
    logic              w_dropNext;

    logic              w_misalign;
    logic              w_reqFire;
    logic              w_load;
    logic [INST_W-1:0] w_loadInst;
    logic              w_loadFault;
    logic              w_kill;
    logic              w_bufValid;

    // A misaligned PC only matters when the check is built in; otherwise the
    // low PC bits are simply dropped from the address.
`ifdef IFU_MISALIGN_CHECK_EN
    assign w_misalign = (r_pc[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // Requests are only offered in REQ and never while reset is held, so
    // memory sees nothing until the first cycle after reset is released.
    assign imem_req_valid = !rst && (r_state == REQ) && !w_misalign;
    assign imem_req_addr  = {r_pc[ADDR_W-1:2], 2'b00};
    assign w_reqFire      = imem_req_valid && imem_req_ready;

    // State, PC and the drop flag. drop marks that the single outstanding
    // request was made stale by a redirect and its response must be eaten.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= REQ;
            r_pc    <= RESET_PC;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_pc    <= w_pcNext;
            r_drop  <= w_dropNext;
        end
    end

    // Next-state logic. A redirect always wins over the normal transition;
    // the cases differ only in what happens to an in-flight request or a
    // held instruction.
    always_comb begin
        w_stateNext = r_state;
        w_pcNext    = r_pc;
        w_dropNext  = r_drop;
        w_load      = 1'b0;
        w_loadInst  = '0;
        w_loadFault = 1'b0;
        w_kill      = 1'b0;

        case (r_state)
            REQ: begin
                if (redirect_valid) begin
                    w_pcNext = redirect_pc;
                    if (w_reqFire) begin
                        w_dropNext  = 1'b1;
                        w_stateNext = WAIT;
                    end
                end else if (w_misalign) begin
                    w_load      = 1'b1;
                    w_loadInst  = '0;
                    w_loadFault = 1'b1;
                    w_stateNext = OUT;
                end else if (w_reqFire) begin
                    w_stateNext = WAIT;
                end
            end

            WAIT: begin
                if (imem_resp_valid) begin
                    if (redirect_valid) begin
                        w_pcNext    = redirect_pc;
                        w_dropNext  = 1'b0;
                        w_stateNext = REQ;
                    end else if (r_drop) begin
                        w_dropNext  = 1'b0;
                        w_stateNext = REQ;
                    end else begin
                        w_load      = 1'b1;
                        w_loadInst  = imem_resp_inst;
                        w_stateNext = OUT;
                    end
                end else if (redirect_valid) begin
                    w_pcNext   = redirect_pc;
                    w_dropNext = 1'b1;
                end
            end

            OUT: begin
                if (redirect_valid) begin
                    w_pcNext    = redirect_pc;
                    w_kill      = 1'b1;
                    w_stateNext = REQ;
                end else if (out_ready) begin
                    w_pcNext    = r_pc + ADDR_W'(4);
                    w_stateNext = REQ;
                end
            end

            default: begin
                w_stateNext = REQ;
            end
        endcase
    end

    // The buffer's pc is captured from r_pc, which cannot change while the
    // FSM sits in OUT, so out_pc always equals the fetch PC there.
    ifu_out_buf #(
        .BUF_ADDR_W (ADDR_W),
        .BUF_INST_W (INST_W)
    ) u_outBuf (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_kill  (w_kill),
        .i_pc    (r_pc),
        .i_inst  (w_loadInst),
        .i_fault (w_loadFault),
        .i_ready (out_ready),
        .o_valid (w_bufValid),
        .o_pc    (out_pc),
        .o_inst  (out_inst),
        .o_fault (out_fault)
    );

    // Without the misalign check nothing ever loads a fault, so out_fault
    // stays at its reset value of 0.
    assign out_valid = w_bufValid && !rst;

endmodule

// File: tb/tb_ifu_fetch.sv
// ---------------------------------------------------------------------------
// tb_ifu_fetch
//
// Self-checking bench for ifu_fetch. A behavioural model tracks the
// architectural fetch PC, whether an instruction is waiting for decode and
// the single outstanding memory request; a memory model answers accepted
// requests after a random latency. Stale responses carry 32'hDEAD_BEEF.
// Directed scenarios run first, followed by randomized traffic with
// redirects and occasional resets.
// ---------------------------------------------------------------------------
module tb_ifu_fetch;

    localparam logic [63:0] RST_PC = 64'h8000_0000;
    localparam logic [31:0] STALE  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_inst;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_fault;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_inst  (imem_resp_inst),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_inst        (out_inst),
        .out_fault       (out_fault)
    );

    int checks   = 0;
    int failures = 0;

    // Model state
    logic [63:0] expPc;
    bit          hasInst;
    bit          pendValid;
    bit          pendStale;
    logic [63:0] pendAddr;
    int          pendWait;
    int          latMin;
    int          latMax;
    bit          useFixed;
    logic [31:0] fixedData;

    // What the DUT actually handed over, logged at handshake time
    logic [63:0] reqLog[$];
    logic [63:0] outPcLog[$];
    logic [31:0] outInstLog[$];
    logic        outFaultLog[$];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] memData(input logic [63:0] a);
        if (useFixed) return fixedData;
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0003;
    endfunction

    function automatic bit faultExpected(input logic [63:0] p);
`ifdef IFU_MISALIGN_CHECK_EN
        return (p[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [63:0] alignW(input logic [63:0] p);
        return {p[63:2], 2'b00};
    endfunction

    function automatic logic [63:0] randTarget();
        logic [63:0] t;
        t = 64'h8000_0000 + 64'($urandom_range(0, 255)) * 64'd4;
        if ($urandom_range(0, 7) == 0) t = t + 64'($urandom_range(1, 3));
        if ($urandom_range(0, 15) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3)) * 64'd4;
        return t;
    endfunction

    function automatic void clearLogs();
        reqLog.delete();
        outPcLog.delete();
        outInstLog.delete();
        outFaultLog.delete();
    endfunction

    // One clock cycle, called at a falling edge: compare the DUT against the
    // model, drive the inputs for the next rising edge, log handshakes, then
    // advance the model to what that rising edge must do.
    task automatic applyStimulus(input bit rstV, input bit reqReady, input bit outReady,
                                 input bit redirV, input logic [63:0] redirPc);
        bit          curRst;
        bit          expReq;
        bit          respNow;
        bit          oldHas;
        bit          oldPend;
        bit          reqFire;
        bit          outFire;
        logic [63:0] oldPc;

        curRst = rst;
        expReq = !hasInst && !pendValid && !faultExpected(expPc);
        if (curRst) begin
            checkOutput("rstReqValid", imem_req_valid, 0);
            checkOutput("rstOutValid", out_valid, 0);
        end else begin
            checkOutput("reqValid", imem_req_valid, expReq);
            checkOutput("outValid", out_valid, hasInst);
            if (imem_req_valid) checkOutput("reqAddr", imem_req_addr, alignW(expPc));
            if (out_valid) begin
                checkOutput("outPc", out_pc, expPc);
                checkOutput("outFault", out_fault, faultExpected(expPc));
                checkOutput("outInst", out_inst, faultExpected(expPc) ? 32'h0 : memData(alignW(expPc)));
            end
        end

        respNow         = !rstV && pendValid && (pendWait == 0);
        rst             = rstV;
        imem_req_ready  = reqReady;
        out_ready       = outReady;
        redirect_valid  = redirV;
        redirect_pc     = redirV ? redirPc : 64'($urandom);
        imem_resp_valid = respNow;
        imem_resp_inst  = respNow ? (pendStale ? STALE : memData(pendAddr)) : $urandom;

        #1;
        if (imem_req_valid && imem_req_ready) reqLog.push_back(imem_req_addr);
        if (out_valid && out_ready) begin
            outPcLog.push_back(out_pc);
            outInstLog.push_back(out_inst);
            outFaultLog.push_back(out_fault);
        end

        if (rstV) begin
            expPc     = RST_PC;
            hasInst   = 1'b0;
            pendValid = 1'b0;
            pendStale = 1'b0;
        end else begin
            oldHas  = hasInst;
            oldPend = pendValid;
            oldPc   = expPc;
            reqFire = expReq && reqReady;
            outFire = oldHas && outReady;

            if (respNow) pendValid = 1'b0;
            else if (pendValid) pendWait--;
            if (respNow && !pendStale && !redirV) hasInst = 1'b1;
            if (!oldHas && !oldPend && faultExpected(oldPc) && !redirV) hasInst = 1'b1;
            if (oldHas && (outFire || redirV)) hasInst = 1'b0;

            if (redirV) begin
                expPc = redirPc;
                if (pendValid) pendStale = 1'b1;
            end else if (outFire) begin
                expPc = oldPc + 64'd4;
            end

            if (reqFire) begin
                pendValid = 1'b1;
                pendStale = redirV;
                pendAddr  = alignW(oldPc);
                pendWait  = $urandom_range(latMin, latMax);
            end
        end

        @(negedge clk);
    endtask

    task automatic idleCycle(input bit reqReady, input bit outReady);
        applyStimulus(1'b0, reqReady, outReady, 1'b0, 64'h0);
    endtask

    initial begin
        logic [63:0] heldPc;
        int          outsBefore;
        int          rstCnt;
        int          randOuts;

        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_inst = '0; out_ready = 1'b0;
        expPc = RST_PC; hasInst = 1'b0; pendValid = 1'b0; pendStale = 1'b0;
        pendAddr = '0; pendWait = 0; latMin = 0; latMax = 0;
        useFixed = 1'b1; fixedData = 32'h0000_0013;
        @(negedge clk);

        // Reset then zero-wait memory returning 0x13
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
        clearLogs();
        for (int i = 0; i < 9; i++) idleCycle(1'b1, 1'b1);
        checkOutput("t1ReqCount", reqLog.size(), 3);
        checkOutput("t1OutCount", outPcLog.size(), 3);
        for (int i = 0; i < 3 && i < reqLog.size(); i++)
            checkOutput("t1ReqAddr", reqLog[i], RST_PC + 64'(i * 4));
        for (int i = 0; i < 3 && i < outPcLog.size(); i++) begin
            checkOutput("t1OutPc", outPcLog[i], RST_PC + 64'(i * 4));
            checkOutput("t1OutInst", outInstLog[i], 32'h0000_0013);
        end

        // Decode backpressure
        useFixed = 1'b0; latMin = 0; latMax = 2;
        for (int i = 0; i < 20 && !hasInst; i++) idleCycle(1'b1, 1'b0);
        heldPc = expPc;
        for (int i = 0; i < 5; i++) idleCycle(1'b1, 1'b0);
        clearLogs();
        idleCycle(1'b1, 1'b1);
        for (int i = 0; i < 10 && reqLog.size() == 0; i++) idleCycle(1'b1, 1'b0);
        checkOutput("t2OutCount", outPcLog.size(), 1);
        checkOutput("t2ReqCount", reqLog.size(), 1);
        if (reqLog.size() > 0) checkOutput("t2NextReq", reqLog[0], alignW(heldPc + 64'd4));

        // Redirect while waiting; the stale word must never reach decode
        for (int i = 0; i < 20 && !hasInst; i++) idleCycle(1'b1, 1'b0);
        idleCycle(1'b0, 1'b1);
        latMin = 3; latMax = 3;
        idleCycle(1'b1, 1'b0);
        clearLogs();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 64'h8000_0100);
        for (int i = 0; i < 20 && outPcLog.size() == 0; i++) idleCycle(1'b1, 1'b1);
        checkOutput("t3ReqCount", reqLog.size(), 1);
        if (reqLog.size() > 0) checkOutput("t3NextReq", reqLog[0], 64'h8000_0100);
        checkOutput("t3OutCount", outPcLog.size(), 1);
        for (int i = 0; i < outInstLog.size(); i++)
            checkOutput("t3NoStale", outInstLog[i] == STALE, 0);

        // Redirect together with an accepted instruction
        latMin = 0; latMax = 1;
        for (int i = 0; i < 20 && !hasInst; i++) idleCycle(1'b1, 1'b0);
        clearLogs();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 64'h8000_0040);
        outsBefore = outPcLog.size();
        for (int i = 0; i < 10 && reqLog.size() == 0; i++) idleCycle(1'b1, 1'b0);
        checkOutput("t4Accepted", outsBefore, 1);
        checkOutput("t4OutCount", outPcLog.size(), 1);
        if (reqLog.size() > 0) checkOutput("t4NextReq", reqLog[0], 64'h8000_0040);

        // Misaligned redirect target
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0002);
        clearLogs();
        for (int i = 0; i < 30 && outPcLog.size() == 0; i++) idleCycle(1'b1, 1'b1);
        checkOutput("t5OutCount", outPcLog.size(), 1);
        if (outPcLog.size() > 0) begin
            checkOutput("t5OutPc", outPcLog[0], 64'h8000_0002);
`ifdef IFU_MISALIGN_CHECK_EN
            checkOutput("t5Fault", outFaultLog[0], 1);
            checkOutput("t5Inst", outInstLog[0], 32'h0);
`else
            checkOutput("t5Fault", outFaultLog[0], 0);
            checkOutput("t5Inst", outInstLog[0], memData(64'h8000_0000));
`endif
        end
`ifdef IFU_MISALIGN_CHECK_EN
        checkOutput("t5ReqCount", reqLog.size(), 0);
`else
        checkOutput("t5ReqCount", reqLog.size(), 1);
        if (reqLog.size() > 0) checkOutput("t5ReqAddr", reqLog[0], 64'h8000_0000);
`endif

        // Wrap-around past the top of the address space
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        clearLogs();
        for (int i = 0; i < 30 && reqLog.size() < 2; i++) idleCycle(1'b1, 1'b1);
        checkOutput("t6ReqCount", reqLog.size(), 2);
        if (reqLog.size() > 1) begin
            checkOutput("t6FirstReq", reqLog[0], 64'hFFFF_FFFF_FFFF_FFFC);
            checkOutput("t6WrapReq", reqLog[1], 64'h0);
        end

        // Randomized traffic
        latMin = 0; latMax = 3; rstCnt = 0;
        clearLogs();
        for (int i = 0; i < 3000; i++) begin
            if (rstCnt == 0 && $urandom_range(0, 299) == 0) rstCnt = 2;
            if (rstCnt > 0) begin
                applyStimulus(1'b1, 1'($urandom), 1'($urandom), 1'b0, 64'h0);
                rstCnt--;
            end else begin
                applyStimulus(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                              1'($urandom_range(0, 11) == 0), randTarget());
            end
        end
        randOuts = outPcLog.size();
        checkOutput("randProgress", randOuts > 100, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
